vga_fb_arbiter: RTL and testbench

- Shares one single-port framebuffer RAM between two users:
  - the VGA display fetch path, which prefetches pixels into a small FWFT pixel FIFO ahead of the pixel painter;
  - a pixel writer (drawing engine or CPU) using a valid/ready handshake.
- Display fetch has priority below a low watermark, so the active display never starves while the writer gets the remaining slots.
- Sits between display_timings/painter and the framebuffer RAM.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_pix_fifo.sv | 58 +++++
 rtl/vga_fb_arbiter.sv | 158 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA framebuffer arbiter.
package vga_pkg;

   localparam int C_H_RES      = 640;
   localparam int C_V_RES      = 480;
   localparam int C_PIX_W      = 12;
   localparam int C_ADDR_W     = 19;
   localparam int C_FIFO_DEPTH = 8;
   localparam int C_LOW_WM     = 4;

   localparam int C_FRAME_PIXELS = C_H_RES * C_V_RES;

   typedef logic [C_PIX_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/vga_pix_fifo.sv
// First-word fall-through pixel FIFO with flush; an incoming word is visible
// on the output in the cycle it is pushed into an empty FIFO.
module vga_pix_fifo #(
   parameter int G_W     = 12,
   parameter int G_DEPTH = 8,
   localparam int L_AW   = $clog2(G_DEPTH)
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_flush,
   input  logic           i_push,
   input  logic [G_W-1:0] i_data,
   input  logic           i_pop,
   output logic [G_W-1:0] o_data,
   output logic           o_valid,
   output logic [L_AW:0]  o_count
);

   logic [G_W-1:0]  mem_q [G_DEPTH];
   logic [L_AW-1:0] wr_ptr_q;
   logic [L_AW-1:0] rd_ptr_q;
   logic [L_AW:0]   count_q;
   logic [L_AW:0]   count_d;
   logic            empty;
   logic            do_wr;
   logic            do_rd;

   assign empty   = (count_q == '0);
   assign o_valid = !empty || i_push;
   assign o_data  = !empty ? mem_q[rd_ptr_q] : (i_push ? i_data : '0);
   assign o_count = count_q;

   // A push and pop on an empty FIFO hand the word straight through.
   assign do_wr   = i_push && !(empty && i_pop);
   assign do_rd   = i_pop && !empty;
   assign count_d = count_q + (L_AW+1)'(do_wr) - (L_AW+1)'(do_rd);

   always_ff @(posedge i_clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= i_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (i_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display prefetch vs. pixel writer.
// Optional statistics counters are enabled with the VGA_ARB_STATS_EN macro.
module vga_fb_arbiter
   import vga_pkg::*;
#(
   parameter int G_H_RES      = C_H_RES,
   parameter int G_V_RES      = C_V_RES,
   parameter int G_PIX_W      = C_PIX_W,
   parameter int G_ADDR_W     = C_ADDR_W,
   parameter int G_FIFO_DEPTH = C_FIFO_DEPTH,
   parameter int G_LOW_WM     = C_LOW_WM
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_frame_start,
   input  logic                i_pix_req,
   output logic [G_PIX_W-1:0]  o_pix,
   output logic                o_pix_valid,
   output logic                o_underflow,
   // Writer handshake: a write transfers in any cycle where i_wr_valid and
   // o_wr_ready are both high; o_wr_ready never looks at i_wr_valid.
   input  logic                i_wr_valid,
   output logic                o_wr_ready,
   input  logic [G_ADDR_W-1:0] i_wr_addr,
   input  logic [G_PIX_W-1:0]  i_wr_data,
   output logic                o_mem_en,
   output logic                o_mem_we,
   output logic [G_ADDR_W-1:0] o_mem_addr,
   output logic [G_PIX_W-1:0]  o_mem_wdata,
   input  logic [G_PIX_W-1:0]  i_mem_rdata,
   output arb_state_t          o_state
`ifdef VGA_ARB_STATS_EN
   ,
   output logic [15:0]         o_underflow_cnt,
   output logic [15:0]         o_wr_stall_cnt
`endif
);

   localparam int L_FRAME = G_H_RES * G_V_RES;
   localparam int L_CW    = $clog2(G_FIFO_DEPTH) + 1;
   localparam logic [G_ADDR_W-1:0] L_LAST = G_ADDR_W'(L_FRAME - 1);

   arb_state_t          state_q;
   logic [G_ADDR_W-1:0] fetch_addr_q;
   logic [1:0]          rd_pipe_q;
   logic                mem_en_q;
   logic                mem_we_q;
   logic [G_ADDR_W-1:0] mem_addr_q;
   logic [G_PIX_W-1:0]  mem_wdata_q;
   logic                underflow_q;

   logic [L_CW-1:0]     fifo_count;
   logic                fifo_valid;
   logic [L_CW:0]       occupancy;
   logic                wr_ready;
   logic                wr_hs;
   logic                wr_in_frame;
   logic                wr_issue;
   logic                rd_grant;
   logic                underflow_ev;

   // Reads in the command register and in the RAM count as already owned.
   assign occupancy = {1'b0, fifo_count} + (L_CW+1)'(rd_pipe_q[0]) + (L_CW+1)'(rd_pipe_q[1]);

   always_comb begin
      wr_ready = 1'b0;
      if (!i_rst) begin
         if (state_q == S_RUN) wr_ready = (occupancy >= (L_CW+1)'(G_LOW_WM));
         else                  wr_ready = 1'b1;
      end
   end

   assign wr_hs        = i_wr_valid && wr_ready;
   assign wr_in_frame  = ({1'b0, i_wr_addr} < (G_ADDR_W+1)'(L_FRAME));
   assign wr_issue     = wr_hs && wr_in_frame;
   assign rd_grant     = (state_q == S_RUN) && !wr_hs && !i_frame_start &&
                         (occupancy < (L_CW+1)'(G_FIFO_DEPTH));
   assign underflow_ev = i_pix_req && !fifo_valid && !i_frame_start;

   vga_pix_fifo #(
      .G_W     (G_PIX_W),
      .G_DEPTH (G_FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_frame_start),
      .i_push  (rd_pipe_q[1] && !i_frame_start),
      .i_data  (i_mem_rdata),
      .i_pop   (i_pix_req && !i_frame_start),
      .o_data  (o_pix),
      .o_valid (fifo_valid),
      .o_count (fifo_count)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         fetch_addr_q <= '0;
         rd_pipe_q    <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         underflow_q  <= 1'b0;
      end else begin
         mem_en_q <= wr_issue || rd_grant;
         mem_we_q <= wr_issue;
         if (wr_issue) begin
            mem_addr_q  <= i_wr_addr;
            mem_wdata_q <= i_wr_data;
         end else if (rd_grant) begin
            mem_addr_q  <= fetch_addr_q;
         end
         // A frame restart drops every read still travelling through the RAM.
         rd_pipe_q <= i_frame_start ? 2'b00 : {rd_pipe_q[0], rd_grant};
         if (i_frame_start)     underflow_q <= 1'b0;
         else if (underflow_ev) underflow_q <= 1'b1;
         if (i_frame_start) begin
            state_q      <= S_RUN;
            fetch_addr_q <= '0;
         end else if (rd_grant) begin
            fetch_addr_q <= fetch_addr_q + 1'b1;
            if (fetch_addr_q == L_LAST) state_q <= S_DONE;
         end
      end
   end

   assign o_pix_valid = fifo_valid;
   assign o_underflow = underflow_q;
   assign o_wr_ready  = wr_ready;
   assign o_mem_en    = mem_en_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_state     = state_q;

`ifdef VGA_ARB_STATS_EN
   logic [15:0] uf_cnt_q;
   logic [15:0] stall_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         uf_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else if (i_frame_start) begin
         uf_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (underflow_ev && (uf_cnt_q != 16'hFFFF))             uf_cnt_q    <= uf_cnt_q + 1'b1;
         if (i_wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign o_underflow_cnt = uf_cnt_q;
   assign o_wr_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter on a reduced 16x8 frame, checked
// against a transaction-level model of fetch order, latency and arbitration.
module tb_vga_fb_arbiter;
   import vga_pkg::*;

   localparam int H     = 16;
   localparam int V     = 8;
   localparam int PW    = 12;
   localparam int AW    = 19;
   localparam int DEPTH = 8;
   localparam int WM    = 4;
   localparam int FRAME = H * V;
   localparam int WW    = AW + PW;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_start;
   logic          pix_req;
   logic [PW-1:0] pix;
   logic          pix_valid;
   logic          underflow;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [PW-1:0] wr_data;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [PW-1:0] mem_wdata;
   logic [PW-1:0] mem_rdata = '0;
   arb_state_t    dbg_state;
`ifdef VGA_ARB_STATS_EN
   logic [15:0]   uf_cnt;
   logic [15:0]   stall_cnt;
`endif

   always #5 clk = ~clk;

   vga_fb_arbiter #(
      .G_H_RES      (H),
      .G_V_RES      (V),
      .G_PIX_W      (PW),
      .G_ADDR_W     (AW),
      .G_FIFO_DEPTH (DEPTH),
      .G_LOW_WM     (WM)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_frame_start (frame_start),
      .i_pix_req     (pix_req),
      .o_pix         (pix),
      .o_pix_valid   (pix_valid),
      .o_underflow   (underflow),
      .i_wr_valid    (wr_valid),
      .o_wr_ready    (wr_ready),
      .i_wr_addr     (wr_addr),
      .i_wr_data     (wr_data),
      .o_mem_en      (mem_en),
      .o_mem_we      (mem_we),
      .o_mem_addr    (mem_addr),
      .o_mem_wdata   (mem_wdata),
      .i_mem_rdata   (mem_rdata),
      .o_state       (dbg_state)
`ifdef VGA_ARB_STATS_EN
      ,
      .o_underflow_cnt (uf_cnt),
      .o_wr_stall_cnt  (stall_cnt)
`endif
   );

   // Synchronous single-port RAM, read data one cycle after the strobe.
   logic [PW-1:0] ram [FRAME];
   initial for (int i = 0; i < FRAME; i++) ram[i] = PW'($urandom_range(0, 4095));
   always @(posedge clk) begin
      if (mem_en && (int'(mem_addr) < FRAME)) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
   endtask

   // Reference model state.
   int            cyc = 0;
   int            m_mode = 0;          // 0 idle, 1 run, 2 done
   int            m_addr = 0;
   bit            m_uf = 0;
   bit            pend_rd = 0;
   int            pend_rd_addr = 0;
   int            m_uf_cnt = 0;
   int            m_stall_cnt = 0;
   int            n_wr_acc = 0;
   logic [WW-1:0] exp_q[$];
   logic [PW-1:0] pix_q[$];
   int            pix_t[$];

   task automatic check_cycle();
      int            occ;
      bit            exp_ready;
      bit            ev;
      bit            hs;
      logic [WW-1:0] e;
      check_eq("state", dbg_state, m_mode);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("wr_mem_en", mem_en, 1);
         check_eq("wr_mem_we", mem_we, 1);
         check_eq("wr_mem_addr", mem_addr, e[WW-1:PW]);
         check_eq("wr_mem_wdata", mem_wdata, e[PW-1:0]);
      end else if (pend_rd) begin
         check_eq("rd_mem_en", mem_en, 1);
         check_eq("rd_mem_we", mem_we, 0);
         check_eq("rd_mem_addr", mem_addr, pend_rd_addr);
         pix_q.push_back(ram[pend_rd_addr]);
         pix_t.push_back(cyc + 1);
      end else begin
         check_eq("mem_idle", mem_en, 0);
      end
      pend_rd = 0;
      occ = pix_q.size();
      exp_ready = (m_mode == 1) ? (occ >= WM) : 1'b1;
      check_eq("wr_ready", wr_ready, exp_ready);
      check_eq("underflow", underflow, m_uf);
      ev = (pix_q.size() > 0) && (pix_t[0] <= cyc);
      check_eq("pix_valid", pix_valid, ev);
      check_eq("pix", pix, ev ? 32'(pix_q[0]) : 32'd0);
`ifdef VGA_ARB_STATS_EN
      check_eq("uf_cnt", uf_cnt, m_uf_cnt);
      check_eq("stall_cnt", stall_cnt, m_stall_cnt);
`endif
      if (wr_valid && !exp_ready && m_stall_cnt < 65535) m_stall_cnt++;
      if (pix_req) begin
         if (ev) begin
            void'(pix_q.pop_front());
            void'(pix_t.pop_front());
         end else begin
            m_uf = 1;
            if (m_uf_cnt < 65535) m_uf_cnt++;
         end
      end
      hs = wr_valid && exp_ready;
      if (hs) begin
         n_wr_acc++;
         if (int'(wr_addr) < FRAME) exp_q.push_back({wr_addr, wr_data});
      end
      if (frame_start) begin
         pix_q.delete();
         pix_t.delete();
         m_addr = 0;
         m_mode = 1;
         m_uf = 0;
         m_uf_cnt = 0;
         m_stall_cnt = 0;
      end else if (m_mode == 1 && !hs && occ < DEPTH) begin
         pend_rd = 1;
         pend_rd_addr = m_addr;
         if (m_addr == FRAME - 1) m_mode = 2;
         m_addr++;
      end
      cyc++;
   endtask

   task automatic drive(input bit f, input bit pr, input bit wv, input int wa, input int wd);
      @(posedge clk);
      #1;
      frame_start = f;
      pix_req     = pr;
      wr_valid    = wv;
      wr_addr     = AW'(wa);
      wr_data     = PW'(wd);
      @(negedge clk);
      check_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  acc0;
      bit  got;
      bit  done;
      rst = 1'b1;
      frame_start = 1'b0;
      pix_req = 1'b0;
      wr_valid = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_wr_ready", wr_ready, 0);
      check_eq("rst_pix_valid", pix_valid, 0);
      check_eq("rst_underflow", underflow, 0);
      check_eq("rst_state", dbg_state, S_IDLE);
      @(posedge clk);
      #1 rst = 1'b0;

      // Before any frame: painter underflows, writer owns the RAM.
      for (int i = 0; i < 6; i++)
         drive(0, 1, 1, $urandom_range(0, FRAME - 1), $urandom_range(0, 4095));
      check_eq("idle_underflow_set", underflow, 1);

      // Frame start with no writer: prefetch fills the FIFO.
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0);

      // Restart, then hold one write until the watermark lets it through.
      drive(1, 0, 0, 0, 0);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         acc0 = n_wr_acc;
         drive(0, 0, 1, 100, 'hABC);
         if (n_wr_acc > acc0) got = 1;
      end
      check_eq("held_write_accepted", got, 1);
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0);

      // Painter and writer both active every cycle.
      acc0 = n_wr_acc;
      for (int i = 0; i < 40; i++)
         drive(0, 1, 1, $urandom_range(0, FRAME - 1), $urandom_range(0, 4095));
      check_eq("writes_during_display", (n_wr_acc > acc0), 1);
      check_eq("no_underflow_during_display", underflow, 0);

      // Mid-frame restart with reads in flight.
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) drive(0, 0, 0, 0, 0);

      // Random traffic until the whole frame has been fetched and drained.
      done = 0;
      for (int i = 0; i < 4000 && !done; i++) begin
         drive(0, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 30),
               $urandom_range(0, FRAME + 20), $urandom_range(0, 4095));
         done = (m_mode == 2) && (pix_q.size() == 0) && (exp_q.size() == 0) && !pend_rd;
      end
      check_eq("frame_completed", done, 1);
      check_eq("done_state", dbg_state, S_DONE);
      check_eq("done_wr_ready", wr_ready, 1);

      // Out-of-frame write is accepted and dropped.
      drive(0, 0, 1, FRAME, 'h123);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
